op_responder: RTL and testbench

OP_RESPONDER -- requirements
Module: op_responder

---
 rtl/dut_pkg.sv | 43 ++++
 rtl/seq_muldiv.sv | 126 ++++++++++++
 rtl/op_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_op_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dut_pkg.sv
// rtl/dut_pkg.sv - shared opcodes, status codes, FSM states and helpers for op_responder
package dut_pkg;

    // Opcode encoding carried on the 8-bit op input; any value above OP_WMR is illegal.
    typedef enum logic [7:0] {
        OP_NOP = 8'd0,
        OP_ADD = 8'd1,
        OP_AND = 8'd2,
        OP_XOR = 8'd3,
        OP_MUL = 8'd4,
        OP_DIV = 8'd5,
        OP_LDA = 8'd6,
        OP_STA = 8'd7,
        OP_MOV = 8'd8,
        OP_SWP = 8'd9,
        OP_WMR = 8'd10
    } operation_t;

    localparam logic [7:0] ERR_OK      = 8'd0;
    localparam logic [7:0] ERR_ILLEGAL = 8'd1;
    localparam logic [7:0] ERR_DIV0    = 8'd2;
    localparam logic [7:0] ERR_ADDR    = 8'd3;

    localparam int MEM_DEPTH = 16;
    localparam int MEM_AW    = $clog2(MEM_DEPTH);
    localparam int MD_ITERS  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    // Flag reported alongside every result: strictly positive when signed, non-zero otherwise.
    function automatic logic calc_gp(input logic [63:0] res, input logic sgn);
        if (sgn) begin
            return $signed(res) > 64'sd0;
        end
        return res != 64'd0;
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// rtl/seq_muldiv.sv - 32-step shift-add multiplier and restoring divider (divider under OP_RESPONDER_DIV_EN)
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start_i             load operands; the first step is performed on the same edge
//   is_div_i            1 = divide, 0 = multiply (ignored unless OP_RESPONDER_DIV_EN)
//   sv_i                1 = signed operands
//   a_i, b_i            multiplier/multiplicand or dividend/divisor
//   busy_o              stepping in progress
//   done_o              one-cycle pulse once all 32 steps are complete
//   result_o            product, or {remainder, quotient}; valid from done_o until next start
module seq_muldiv
    import dut_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        is_div_i,
    input  logic        sv_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [63:0] result_o
);

    // Both datapaths work on magnitudes; signs are reapplied on the way out.
    // w_q holds {partial product hi, remaining multiplier} or {remainder, dividend/quotient}.
    logic [63:0] w_q;
    logic [31:0] m_q;
    logic [4:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic        neg_q;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [63:0] src_w;
    logic [31:0] src_m;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [63:0] step_w;

    assign abs_a = (sv_i && a_i[31]) ? -a_i : a_i;
    assign abs_b = (sv_i && b_i[31]) ? -b_i : b_i;

    // On start the step operates on the freshly loaded operands, so 32 steps end one
    // edge earlier than a separate load cycle would allow.
    assign src_w = start_i ? {32'd0, abs_a} : w_q;
    assign src_m = start_i ? abs_b : m_q;

    assign mul_sum  = {1'b0, src_w[63:32]} + (src_w[0] ? {1'b0, src_m} : 33'd0);
    assign mul_next = {mul_sum, src_w[31:1]};

`ifdef OP_RESPONDER_DIV_EN
    logic        div_q;
    logic        negr_q;
    logic        src_div;
    logic [32:0] div_rs;
    logic [32:0] div_diff;
    logic [31:0] div_rem;
    logic        div_bit;
    logic [63:0] div_next;

    assign src_div  = start_i ? is_div_i : div_q;
    // Shift the next dividend bit into the remainder and try to subtract the divisor.
    assign div_rs   = src_w[63:31];
    assign div_diff = div_rs - {1'b0, src_m};
    assign div_bit  = ~div_diff[32];
    assign div_rem  = div_bit ? div_diff[31:0] : div_rs[31:0];
    assign div_next = {div_rem, src_w[30:0], div_bit};

    assign step_w = src_div ? div_next : mul_next;

    // Quotient truncates toward zero; remainder follows the sign of the dividend.
    assign result_o = div_q ? {(negr_q ? -w_q[63:32] : w_q[63:32]),
                               (neg_q  ? -w_q[31:0]  : w_q[31:0])}
                            : (neg_q ? -w_q : w_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= 1'b0;
            negr_q <= 1'b0;
        end else if (start_i) begin
            div_q  <= is_div_i;
            negr_q <= sv_i & a_i[31];
        end
    end
`else
    logic unused_is_div;
    assign unused_is_div = is_div_i;
    assign step_w        = mul_next;
    assign result_o      = neg_q ? -w_q : w_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            w_q    <= '0;
            m_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                w_q    <= step_w;
                m_q    <= abs_b;
                neg_q  <= sv_i & (a_i[31] ^ b_i[31]);
                cnt_q  <= 5'd1;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                w_q   <= step_w;
                cnt_q <= cnt_q + 5'd1;
                if (cnt_q == 5'(MD_ITERS - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: rtl/op_responder.sv
// rtl/op_responder.sv - command responder: ALU ops, 16x32 scratch memory, iterative mul/div (div under OP_RESPONDER_DIV_EN)
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               command request, sampled only in IDLE
//   op                  opcode (dut_pkg::operation_t)
//   A, B                operands; low 4 bits are memory addresses for memory ops
//   sv                  1 = signed arithmetic
//   op_prefix           1 = use the accumulator in place of B
//   done                one-cycle completion pulse
//   result, err, gp     command result, status code and flag, held until next done
// Define OP_RESPONDER_DIV_EN to build the divider; otherwise op 5 is illegal.
module op_responder
    import dut_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        sv,
    input  logic        op_prefix,
    output logic        done,
    output logic [63:0] result,
    output logic [7:0]  err,
    output logic        gp
);

    state_t      state_q;
    logic [7:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        sv_q;
    logic [31:0] acc_q;
    logic [31:0] mem_q [MEM_DEPTH];
    logic        done_q;
    logic [63:0] result_q;
    logic [7:0]  err_q;
    logic        gp_q;

    logic              a_ok;
    logic              b_ok;
    logic [MEM_AW-1:0] ia;
    logic [MEM_AW-1:0] ib;

    logic [63:0] exec_res;
    logic [7:0]  exec_err;
    logic        wa_en;
    logic [31:0] wa_data;
    logic        wb_en;
    logic [31:0] wb_data;
    logic        md_go;

    logic        md_start;
    logic        md_is_div;
    logic        md_busy;
    logic        md_done;
    logic [63:0] md_res;

    assign a_ok = a_q < 32'(MEM_DEPTH);
    assign b_ok = b_q < 32'(MEM_DEPTH);
    assign ia   = a_q[MEM_AW-1:0];
    assign ib   = b_q[MEM_AW-1:0];

    // Single-cycle datapath, evaluated on the latched command during EXEC.
    always_comb begin
        exec_res = '0;
        exec_err = ERR_OK;
        wa_en    = 1'b0;
        wa_data  = '0;
        wb_en    = 1'b0;
        wb_data  = '0;
        md_go    = 1'b0;
        case (op_q)
            OP_NOP: ;
            OP_ADD: exec_res = {{32{sv_q & a_q[31]}}, a_q} + {{32{sv_q & b_q[31]}}, b_q};
            OP_AND: exec_res = {32'd0, a_q & b_q};
            OP_XOR: exec_res = {32'd0, a_q ^ b_q};
            OP_MUL: md_go = 1'b1;
`ifdef OP_RESPONDER_DIV_EN
            OP_DIV: begin
                if (b_q == 32'd0) begin
                    exec_err = ERR_DIV0;
                end else begin
                    md_go = 1'b1;
                end
            end
`endif
            OP_LDA: begin
                if (!a_ok) begin
                    exec_err = ERR_ADDR;
                end else begin
                    exec_res = {32'd0, mem_q[ia]};
                end
            end
            OP_STA: begin
                if (!a_ok) begin
                    exec_err = ERR_ADDR;
                end else begin
                    exec_res = {32'd0, b_q};
                    wa_en    = 1'b1;
                    wa_data  = b_q;
                end
            end
            OP_MOV: begin
                if (!(a_ok && b_ok)) begin
                    exec_err = ERR_ADDR;
                end else begin
                    exec_res = {32'd0, mem_q[ib]};
                    wa_en    = 1'b1;
                    wa_data  = mem_q[ib];
                end
            end
            OP_SWP: begin
                if (!(a_ok && b_ok)) begin
                    exec_err = ERR_ADDR;
                end else begin
                    exec_res = {mem_q[ia], mem_q[ib]};
                    wa_en    = 1'b1;
                    wa_data  = mem_q[ib];
                    // Same address: a single write of the unchanged value is enough.
                    wb_en    = (ia != ib);
                    wb_data  = mem_q[ia];
                end
            end
            OP_WMR: begin
                if (!a_ok) begin
                    exec_err = ERR_ADDR;
                end else begin
                    exec_res = {32'd0, mem_q[ia]};
                    wa_en    = 1'b1;
                    wa_data  = b_q;
                end
            end
            default: exec_err = ERR_ILLEGAL;
        endcase
    end

`ifdef OP_RESPONDER_DIV_EN
    assign md_is_div = (op_q == OP_DIV);
`else
    assign md_is_div = 1'b0;
`endif
    assign md_start = (state_q == EXEC) && md_go && !md_busy;

    seq_muldiv u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .start_i  (md_start),
        .is_div_i (md_is_div),
        .sv_i     (sv_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .result_o (md_res)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sv_q     <= 1'b0;
            acc_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            err_q    <= ERR_OK;
            gp_q     <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q    <= op;
                        a_q     <= A;
                        b_q     <= op_prefix ? acc_q : B;
                        sv_q    <= sv;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (md_go) begin
                        state_q <= ITER;
                    end else begin
                        result_q <= exec_res;
                        err_q    <= exec_err;
                        gp_q     <= calc_gp(exec_res, sv_q);
                        done_q   <= 1'b1;
                        if (exec_err == ERR_OK) begin
                            acc_q <= exec_res[31:0];
                        end
                        if (wa_en) begin
                            mem_q[ia] <= wa_data;
                        end
                        if (wb_en) begin
                            mem_q[ib] <= wb_data;
                        end
                        state_q <= DONE;
                    end
                end
                ITER: begin
                    if (md_done) begin
                        result_q <= md_res;
                        err_q    <= ERR_OK;
                        gp_q     <= calc_gp(md_res, sv_q);
                        acc_q    <= md_res[31:0];
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done   = done_q;
    assign result = result_q;
    assign err    = err_q;
    assign gp     = gp_q;

endmodule

// File: tb/tb_op_responder.sv
// tb/tb_op_responder.sv - scoreboard testbench for op_responder
module tb_op_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        sv;
    logic        op_prefix;
    logic        done;
    logic [63:0] result;
    logic [7:0]  err;
    logic        gp;

    typedef struct {
        logic [63:0] res;
        logic [7:0]  err;
        logic        gp;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_mem [16];
    logic [31:0] m_acc;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] last_res;
    logic [7:0]  last_err;

    op_responder dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .A         (A),
        .B         (B),
        .sv        (sv),
        .op_prefix (op_prefix),
        .done      (done),
        .result    (result),
        .err       (err),
        .gp        (gp)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        m_acc = '0;
    endtask

    // Reference behaviour of one command; pushes the expected response.
    task automatic model_op(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b_in,
                            input logic s, input logic p);
        exp_t e;
        logic [31:0] b;
        logic signed [63:0] sa, sb, q, r;
        logic [31:0] tmp;
        b     = p ? m_acc : b_in;
        sa    = {{32{a[31]}}, a};
        sb    = {{32{b[31]}}, b};
        e.res = '0;
        e.err = 8'd0;
        e.lat = 2;
        case (o)
            8'd0: ;
            8'd1: e.res = s ? sa + sb : {32'd0, a} + {32'd0, b};
            8'd2: e.res = {32'd0, a & b};
            8'd3: e.res = {32'd0, a ^ b};
            8'd4: begin
                e.res = s ? sa * sb : {32'd0, a} * {32'd0, b};
                e.lat = 34;
            end
            8'd5: begin
`ifdef OP_RESPONDER_DIV_EN
                if (b == 0) begin
                    e.err = 8'd2;
                end else begin
                    if (s) begin
                        q = sa / sb;
                        r = sa % sb;
                    end else begin
                        q = {32'd0, a} / {32'd0, b};
                        r = {32'd0, a} % {32'd0, b};
                    end
                    e.res = {r[31:0], q[31:0]};
                    e.lat = 34;
                end
`else
                e.err = 8'd1;
`endif
            end
            8'd6: if (a > 15) e.err = 8'd3; else e.res = {32'd0, m_mem[a[3:0]]};
            8'd7: if (a > 15) e.err = 8'd3; else begin e.res = {32'd0, b}; m_mem[a[3:0]] = b; end
            8'd8: if (a > 15 || b > 15) e.err = 8'd3;
                  else begin e.res = {32'd0, m_mem[b[3:0]]}; m_mem[a[3:0]] = m_mem[b[3:0]]; end
            8'd9: if (a > 15 || b > 15) e.err = 8'd3;
                  else begin
                      e.res = {m_mem[a[3:0]], m_mem[b[3:0]]};
                      tmp = m_mem[a[3:0]];
                      m_mem[a[3:0]] = m_mem[b[3:0]];
                      m_mem[b[3:0]] = tmp;
                  end
            8'd10: if (a > 15) e.err = 8'd3;
                   else begin e.res = {32'd0, m_mem[a[3:0]]}; m_mem[a[3:0]] = b; end
            default: e.err = 8'd1;
        endcase
        e.gp = s ? ($signed(e.res) > 64'sd0) : (e.res != 64'd0);
        if (e.err == 8'd0) m_acc = e.res[31:0];
        sb_q.push_back(e);
    endtask

    // Drive one command, wait (bounded) for done and compare against the scoreboard head.
    task automatic run_op(input string tag, input logic [7:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic s, input logic p);
        exp_t e;
        int   lat;
        model_op(o, a, b, s, p);
        op = o; A = a; B = b; sv = s; op_prefix = p; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb_q.pop_front();
        check_eq({tag, ".latency"}, 64'(lat), 64'(e.lat));
        check_eq({tag, ".result"}, result, e.res);
        check_eq({tag, ".err"}, 64'(err), 64'(e.err));
        check_eq({tag, ".gp"}, 64'(gp), 64'(e.gp));
        last_res = result;
        last_err = err;
        @(posedge clk); #1;
        check_eq({tag, ".pulse"}, 64'(done), 64'd0);
        check_eq({tag, ".hold"}, result, e.res);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        saw;
        exp_t        e;
        int          lat;
        logic [7:0]  ro;
        logic [31:0] ra, rb;

        reset = 1'b1; start = 1'b0; op = '0; A = '0; B = '0; sv = 1'b0; op_prefix = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset.done", 64'(done), 64'd0);
        check_eq("reset.result", result, 64'd0);
        check_eq("reset.err", 64'(err), 64'd0);
        check_eq("reset.gp", 64'(gp), 64'd0);
        reset = 1'b0;

        run_op("add_u", 8'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        check_eq("add_u.const", last_res, 64'h1_0000_0000);
        run_op("add_s", 8'd1, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
        check_eq("add_s.const", last_res, 64'd0);
        run_op("mul_s", 8'd4, 32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0);
        check_eq("mul_s.const", last_res, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mul_u", 8'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("div_s", 8'd5, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
`ifdef OP_RESPONDER_DIV_EN
        check_eq("div_s.const", last_res, 64'hFFFF_FFFF_FFFF_FFFD);
`else
        check_eq("div_s.illegal", 64'(last_err), 64'd1);
`endif
        run_op("div_0", 8'd5, 32'd9, 32'd0, 1'b0, 1'b0);
        run_op("sta", 8'd7, 32'd3, 32'h55, 1'b0, 1'b0);
        run_op("swp", 8'd9, 32'd3, 32'd4, 1'b0, 1'b0);
        check_eq("swp.const", last_res, 64'h0000_0055_0000_0000);
        run_op("lda4", 8'd6, 32'd4, 32'd0, 1'b0, 1'b0);
        check_eq("lda4.const", last_res, 64'h55);
        run_op("lda16", 8'd6, 32'd16, 32'd0, 1'b0, 1'b0);
        check_eq("lda16.err", 64'(last_err), 64'd3);
        run_op("add55", 8'd1, 32'd5, 32'd5, 1'b0, 1'b0);
        run_op("and_pre", 8'd2, 32'hF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        check_eq("and_pre.const", last_res, 64'hA);
        run_op("mov_same", 8'd8, 32'd4, 32'd4, 1'b0, 1'b0);
        run_op("wmr", 8'd10, 32'd4, 32'h1234, 1'b0, 1'b0);
        run_op("nop", 8'd0, 32'd7, 32'd7, 1'b1, 1'b0);
        run_op("ill11", 8'd11, 32'd1, 32'd1, 1'b0, 1'b0);
        run_op("ill200", 8'd200, 32'd1, 32'd1, 1'b0, 1'b0);

        // A start raised during the DONE cycle must be dropped.
        model_op(8'd1, 32'd1, 32'd2, 1'b0, 1'b0);
        op = 8'd1; A = 32'd1; B = 32'd2; sv = 1'b0; op_prefix = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb_q.pop_front();
        check_eq("dstart.result", result, e.res);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        saw   = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw = 1'b1;
        end
        check_eq("dstart.ignored", 64'(saw), 64'd0);

        for (int i = 0; i < 24; i++) begin
            ro = 8'($urandom_range(0, 12));
            if (ro >= 8'd6 && ro <= 8'd10) begin
                ra = $urandom_range(0, 17);
                rb = (ro == 8'd7 || ro == 8'd10) ? $urandom : $urandom_range(0, 17);
            end else begin
                ra = $urandom;
                rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            end
            run_op($sformatf("rnd%0d", i), ro, ra, rb, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of a multiply, with start held high during reset.
        op = 8'd4; A = 32'hFFFF_FFFD; B = 32'd7; sv = 1'b1; op_prefix = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        saw   = 1'b0;
        repeat (11) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw = 1'b1;
        end
        reset = 1'b1; start = 1'b1; op = 8'd1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        model_reset();
        check_eq("midrst.done", 64'(done), 64'd0);
        check_eq("midrst.result", result, 64'd0);
        check_eq("midrst.err", 64'(err), 64'd0);
        check_eq("midrst.gp", 64'(gp), 64'd0);
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw = 1'b1;
        end
        check_eq("midrst.no_done", 64'(saw), 64'd0);
        run_op("post_pre", 8'd1, 32'd7, 32'd99, 1'b0, 1'b1);
        check_eq("post_pre.const", last_res, 64'd7);
        run_op("post_lda", 8'd6, 32'd4, 32'd0, 1'b0, 1'b0);
        check_eq("post_lda.const", last_res, 64'd0);
        run_op("post_add", 8'd1, 32'd2, 32'd3, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
